// File: rtl/rt_pkg.sv
// Shared ray-tracing fixed-point definitions.
// Used by the intersection stage and by closest_hit.
//   fixed_t   : signed Q16.16 distance
//   FIXED_ONE : 1.0 in Q16.16
//   FIXED_MAX : largest representable distance (ray far clip default)
package rt_pkg;

  typedef logic signed [31:0] fixed_t;

  localparam fixed_t FIXED_ONE = 32'sh0001_0000;
  localparam fixed_t FIXED_MAX = 32'sh7FFF_FFFF;

endpackage

// File: rtl/closest_hit.sv
// closest_hit: reduces a ray's stream of per-triangle intersection results to a single
// nearest-hit summary.
//
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_start        : pulse, begin a new ray; samples i_num_tris (and i_any_mode if enabled)
//   i_num_tris     : number of results expected for the ray
//   i_any_mode     : (only with CLOSEST_HIT_ANY_EN) finish the ray on its first accepted hit
//   i_valid        : intersection result valid
//   i_result       : intersection hit flag
//   i_t            : intersection distance, signed Q16.16
//   o_busy         : collecting results for a ray
//   o_valid        : one-cycle pulse, summary outputs valid
//   o_hit          : at least one accepted hit
//   o_t            : nearest accepted t, T_FAR if no hit
//   o_tri_id       : arrival index of the nearest hit, 0 if no hit
//
// Optional feature macro: CLOSEST_HIT_ANY_EN (any-hit early-out for shadow rays).
module closest_hit
  import rt_pkg::*;
#(
  parameter int unsigned TRI_ID_W = 16,
  parameter fixed_t      T_FAR    = FIXED_MAX
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [TRI_ID_W-1:0] i_num_tris,
`ifdef CLOSEST_HIT_ANY_EN
  input  logic                i_any_mode,
`endif
  input  logic                i_valid,
  input  logic                i_result,
  input  fixed_t              i_t,
  output logic                o_busy,
  output logic                o_valid,
  output logic                o_hit,
  output fixed_t              o_t,
  output logic [TRI_ID_W-1:0] o_tri_id
);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e                state_q, state_d;
  logic [TRI_ID_W-1:0]   count_q, count_d;
  logic [TRI_ID_W-1:0]   num_q, num_d;
  fixed_t                best_t_q, best_t_d;
  logic [TRI_ID_W-1:0]   best_id_q, best_id_d;
  logic                  hit_q, hit_d;
  logic                  any_q, any_d;
  logic                  out_hit_q;
  fixed_t                out_t_q;
  logic [TRI_ID_W-1:0]   out_id_q;
  logic                  any_start;
  logic                  accept;

`ifdef CLOSEST_HIT_ANY_EN
  assign any_start = i_any_mode;
`else
  assign any_start = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    num_d     = num_q;
    best_t_d  = best_t_q;
    best_id_d = best_id_q;
    hit_d     = hit_q;
    any_d     = any_q;
    accept    = 1'b0;

    unique case (state_q)
      StIdle: ;
      StCollect: begin
        if (i_valid) begin
          // Strict compare: an equal t keeps the earlier index.
          accept  = i_result && (i_t < best_t_q);
          count_d = count_q + 1'b1;
          if (accept) begin
            best_t_d  = i_t;
            best_id_d = count_q;
            hit_d     = 1'b1;
          end
          if ((count_q == num_q - 1'b1) || (any_q && accept)) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A start in any state wins: it aborts a ray in flight (dropping a coincident result)
    // or overlaps the DONE cycle, whose outputs were already registered.
    if (i_start) begin
      count_d   = '0;
      num_d     = i_num_tris;
      best_t_d  = T_FAR;
      best_id_d = '0;
      hit_d     = 1'b0;
      any_d     = any_start;
      state_d   = (i_num_tris == '0) ? StDone : StCollect;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      num_q     <= '0;
      best_t_q  <= T_FAR;
      best_id_q <= '0;
      hit_q     <= 1'b0;
      any_q     <= 1'b0;
      out_hit_q <= 1'b0;
      out_t_q   <= T_FAR;
      out_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      num_q     <= num_d;
      best_t_q  <= best_t_d;
      best_id_q <= best_id_d;
      hit_q     <= hit_d;
      any_q     <= any_d;
      // Summary registers load only on entry to DONE and hold until the next one.
      if (state_d == StDone) begin
        out_hit_q <= hit_d;
        out_t_q   <= best_t_d;
        out_id_q  <= best_id_d;
      end
    end
  end

  assign o_busy   = (state_q == StCollect);
  assign o_valid  = (state_q == StDone);
  assign o_hit    = out_hit_q;
  assign o_t      = out_t_q;
  assign o_tri_id = out_id_q;

endmodule

// File: tb/tb_closest_hit.sv
// Directed self-checking bench for closest_hit.
module tb_closest_hit;

  localparam int unsigned W = 16;
  localparam logic signed [31:0] TFAR = 32'sh7FFF_FFFF;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_start = 1'b0;
  logic [W-1:0]      i_num_tris = '0;
  logic              i_any_mode = 1'b0;
  logic              i_valid = 1'b0;
  logic              i_result = 1'b0;
  logic signed [31:0] i_t = '0;
  logic              o_busy, o_valid, o_hit;
  logic signed [31:0] o_t;
  logic [W-1:0]      o_tri_id;

  int n_checks = 0;
  int n_fail   = 0;
  int vcount   = 0;
  int vbase;

  closest_hit #(.TRI_ID_W(W), .T_FAR(TFAR)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_num_tris (i_num_tris),
`ifdef CLOSEST_HIT_ANY_EN
    .i_any_mode (i_any_mode),
`endif
    .i_valid    (i_valid),
    .i_result   (i_result),
    .i_t        (i_t),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_hit      (o_hit),
    .o_t        (o_t),
    .o_tri_id   (o_tri_id)
  );

  always #5 i_clk = ~i_clk;

  // Counts o_valid pulses; reads the pre-edge value of each cycle.
  always @(posedge i_clk) if (o_valid === 1'b1) vcount++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_ray(input int n, input logic any);
    i_start = 1'b1; i_num_tris = W'(n); i_any_mode = any;
    @(negedge i_clk);
    i_start = 1'b0; i_any_mode = 1'b0;
  endtask

  task automatic send(input logic r, input logic signed [31:0] t);
    i_valid = 1'b1; i_result = r; i_t = t;
    @(negedge i_clk);
    i_valid = 1'b0; i_result = 1'b0; i_t = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    check("rst_busy",  o_busy,   0);
    check("rst_valid", o_valid,  0);
    check("rst_hit",   o_hit,    0);
    check("rst_t",     o_t,      TFAR);
    check("rst_id",    o_tri_id, 0);

    // Nearest of three, second is closest.
    start_ray(3, 1'b0);
    check("t1_busy", o_busy, 1);
    send(1'b1, 180224);
    send(1'b1, 65536);
    check("t1_nvalid", o_valid, 0);
    send(1'b0, 0);
    check("t1_valid", o_valid, 1);
    check("t1_hit",   o_hit,   1);
    check("t1_t",     o_t,     65536);
    check("t1_id",    o_tri_id, 1);
    @(negedge i_clk);
    check("t1_pulse", o_valid, 0);
    check("t1_hold",  o_t,     65536);

    // All misses.
    start_ray(2, 1'b0);
    send(1'b0, 100);
    send(1'b0, 200);
    check("t2_valid", o_valid, 1);
    check("t2_hit",   o_hit,   0);
    check("t2_t",     o_t,     TFAR);
    check("t2_id",    o_tri_id, 0);
    @(negedge i_clk);

    // Tie keeps earlier index.
    start_ray(3, 1'b0);
    send(1'b1, 65536);
    send(1'b1, 131072);
    send(1'b1, 65536);
    check("t3_valid", o_valid, 1);
    check("t3_t",     o_t,     65536);
    check("t3_id",    o_tri_id, 0);
    @(negedge i_clk);

    // N=0 then back-to-back N=4.
    start_ray(0, 1'b0);
    check("t4_n0_valid", o_valid, 1);
    check("t4_n0_hit",   o_hit,   0);
    check("t4_n0_busy",  o_busy,  0);
    @(negedge i_clk);
    check("t4_n0_pulse", o_valid, 0);
    start_ray(4, 1'b0);
    send(1'b1, 262144);
    send(1'b1, 196608);
    send(1'b1, 196608);
    check("t4_nvalid", o_valid, 0);
    check("t4_busy",   o_busy,  1);
    send(1'b1, 131072);
    check("t4_valid", o_valid, 1);
    check("t4_hit",   o_hit,   1);
    check("t4_t",     o_t,     131072);
    check("t4_id",    o_tri_id, 3);
    @(negedge i_clk);

    // Abort by restart; the coincident result is dropped.
    vbase = vcount;
    start_ray(4, 1'b0);
    send(1'b1, 65536);
    send(1'b1, 16384);
    i_valid = 1'b1; i_result = 1'b1; i_t = 8192;
    start_ray(1, 1'b0);
    i_valid = 1'b0; i_result = 1'b0; i_t = '0;
    check("t5_busy", o_busy, 1);
    send(1'b1, 32768);
    check("t5_valid", o_valid, 1);
    check("t5_t",     o_t,     32768);
    check("t5_id",    o_tri_id, 0);
    @(negedge i_clk);
    check("t5_count", vcount - vbase, 1);

    // Reset mid-ray.
    vbase = vcount;
    start_ray(3, 1'b0);
    send(1'b1, 4096);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("t6_busy",  o_busy,   0);
    check("t6_valid", o_valid,  0);
    check("t6_hit",   o_hit,    0);
    check("t6_t",     o_t,      TFAR);
    check("t6_id",    o_tri_id, 0);
    send(1'b1, 1024);
    send(1'b1, 2048);
    send(1'b1, 512);
    check("t6_idle_busy", o_busy, 0);
    check("t6_count", vcount - vbase, 0);

`ifdef CLOSEST_HIT_ANY_EN
    // Any-hit early-out.
    start_ray(5, 1'b1);
    send(1'b0, 0);
    send(1'b0, 0);
    send(1'b1, 98304);
    check("t7_valid", o_valid, 1);
    check("t7_hit",   o_hit,   1);
    check("t7_t",     o_t,     98304);
    check("t7_id",    o_tri_id, 2);
    vbase = vcount;
    send(1'b1, 65536);
    send(1'b1, 32768);
    check("t7_busy", o_busy, 0);
    check("t7_count", vcount - vbase, 1);
    check("t7_hold", o_t, 98304);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
